// File: rtl/cpu_mode_ctrl.sv
// CPU clock-mode controller: stalls the CPU, waits for it to go idle,
// flips cmode, holds for a settle time, then releases the CPU.
module cpu_mode_ctrl #(
    parameter int   SETTLE_CYCLES  = 8,
    parameter int   TIMEOUT_CYCLES = 64,
    parameter logic RESET_MODE     = 1'b0
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_mode,
    output logic       req_ready,
    input  logic       cpu_idle,
    output logic       cpu_hold,
    output logic       cmode,
    output logic       busy,
    output logic       done,
    output logic       err_timeout,
    output logic [7:0] sw_count
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SWITCH,
        RELEASE,
        FAIL
    } state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES);
    localparam logic [7:0] ST_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [9:0] wcnt;
    logic [7:0] scnt;
    logic       mode_q;
    logic       noop_q;
    logic       hs;

    assign hs = req_valid & req_ready;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wcnt     <= '0;
            scnt     <= '0;
            mode_q   <= RESET_MODE;
            noop_q   <= 1'b0;
            cmode    <= RESET_MODE;
            sw_count <= '0;
        end else begin
            noop_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        mode_q <= req_mode;
                        if (req_mode == cmode) begin
                            noop_q <= 1'b1;
                        end else begin
                            state <= DRAIN;
                            wcnt  <= 10'd1;
                        end
                    end
                end
                // cpu_idle wins over the timeout in the last wait cycle
                DRAIN: begin
                    if (cpu_idle) begin
                        state <= SWITCH;
                        cmode <= mode_q;
                        wcnt  <= '0;
                        scnt  <= '0;
                    end else if (wcnt == TO_LAST) begin
                        state <= FAIL;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 10'd1;
                    end
                end
                SWITCH: begin
                    if (scnt == ST_LAST) begin
                        state <= RELEASE;
                        scnt  <= '0;
                    end else begin
                        scnt <= scnt + 8'd1;
                    end
                end
                RELEASE: begin
                    state    <= IDLE;
                    sw_count <= sw_count + 8'd1;
                end
                FAIL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign cpu_hold    = (state == DRAIN) || (state == SWITCH);
    assign done        = (state == RELEASE) || noop_q;
    assign err_timeout = (state == FAIL);

endmodule

// File: tb/tb_cpu_mode_ctrl.sv
// Directed bench for cpu_mode_ctrl with SETTLE_CYCLES=8, TIMEOUT_CYCLES=4.
module tb_cpu_mode_ctrl;

    logic       sysclk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_mode = 1'b0;
    logic       cpu_idle = 1'b1;
    logic       req_ready;
    logic       cpu_hold;
    logic       cmode;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic [7:0] sw_count;

    int n_chk = 0;
    int n_fail = 0;

    cpu_mode_ctrl #(
        .SETTLE_CYCLES (8),
        .TIMEOUT_CYCLES(4),
        .RESET_MODE    (1'b0)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_mode   (req_mode),
        .req_ready  (req_ready),
        .cpu_idle   (cpu_idle),
        .cpu_hold   (cpu_hold),
        .cmode      (cmode),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout),
        .sw_count   (sw_count)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic m);
        int k;
        req_valid = 1'b1;
        req_mode  = m;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!done && k < 30) begin
            tick();
            k++;
        end
        chk("run_done", {7'd0, done}, 8'd1);
        tick();
    endtask

    initial begin
        // reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", {7'd0, req_ready}, 8'd1);
        chk("rst_hold", {7'd0, cpu_hold}, 8'd0);
        chk("rst_cmode", {7'd0, cmode}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_err", {7'd0, err_timeout}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_cnt", sw_count, 8'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {7'd0, req_ready}, 8'd1);

        // normal switch 0 -> 1, cpu already idle
        cpu_idle  = 1'b1;
        req_valid = 1'b1;
        req_mode  = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("sw1_c1_hold", {7'd0, cpu_hold}, 8'd1);
        chk("sw1_c1_cmode", {7'd0, cmode}, 8'd0);
        chk("sw1_c1_ready", {7'd0, req_ready}, 8'd0);
        chk("sw1_c1_busy", {7'd0, busy}, 8'd1);
        tick();
        chk("sw1_c2_cmode", {7'd0, cmode}, 8'd1);
        chk("sw1_c2_hold", {7'd0, cpu_hold}, 8'd1);
        for (int i = 3; i <= 9; i++) begin
            tick();
            chk("sw1_settle_hold", {7'd0, cpu_hold}, 8'd1);
            chk("sw1_settle_done", {7'd0, done}, 8'd0);
        end
        tick();
        chk("sw1_c10_done", {7'd0, done}, 8'd1);
        chk("sw1_c10_hold", {7'd0, cpu_hold}, 8'd0);
        chk("sw1_c10_err", {7'd0, err_timeout}, 8'd0);
        chk("sw1_c10_ready", {7'd0, req_ready}, 8'd0);
        tick();
        chk("sw1_c11_ready", {7'd0, req_ready}, 8'd1);
        chk("sw1_c11_done", {7'd0, done}, 8'd0);
        chk("sw1_c11_cnt", sw_count, 8'd1);

        // no-op request (mode equals current cmode)
        req_valid = 1'b1;
        req_mode  = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("noop_done", {7'd0, done}, 8'd1);
        chk("noop_hold", {7'd0, cpu_hold}, 8'd0);
        chk("noop_busy", {7'd0, busy}, 8'd0);
        chk("noop_cnt", sw_count, 8'd1);
        tick();
        chk("noop_done_off", {7'd0, done}, 8'd0);

        // timeout: cpu never idles
        cpu_idle  = 1'b0;
        req_valid = 1'b1;
        req_mode  = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("to_hold", {7'd0, cpu_hold}, 8'd1);
            chk("to_err_early", {7'd0, err_timeout}, 8'd0);
            tick();
        end
        chk("to_c5_err", {7'd0, err_timeout}, 8'd1);
        chk("to_c5_done", {7'd0, done}, 8'd0);
        chk("to_c5_hold", {7'd0, cpu_hold}, 8'd0);
        chk("to_c5_cmode", {7'd0, cmode}, 8'd1);
        tick();
        chk("to_c6_err", {7'd0, err_timeout}, 8'd0);
        chk("to_c6_ready", {7'd0, req_ready}, 8'd1);
        chk("to_c6_cnt", sw_count, 8'd1);

        // cpu_idle rises in the last allowed DRAIN cycle
        req_valid = 1'b1;
        req_mode  = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        cpu_idle = 1'b1;
        chk("late_c4_hold", {7'd0, cpu_hold}, 8'd1);
        tick();
        chk("late_c5_cmode", {7'd0, cmode}, 8'd0);
        chk("late_c5_err", {7'd0, err_timeout}, 8'd0);
        chk("late_c5_hold", {7'd0, cpu_hold}, 8'd1);
        repeat (8) tick();
        chk("late_c13_done", {7'd0, done}, 8'd1);
        tick();
        chk("late_c14_cnt", sw_count, 8'd2);
        chk("late_c14_ready", {7'd0, req_ready}, 8'd1);

        // req_valid held: one switch, then a no-op once back in IDLE
        req_valid = 1'b1;
        req_mode  = 1'b1;
        tick();
        repeat (4) tick();
        chk("held_c5_ready", {7'd0, req_ready}, 8'd0);
        repeat (5) tick();
        chk("held_c10_done", {7'd0, done}, 8'd1);
        tick();
        chk("held_c11_ready", {7'd0, req_ready}, 8'd1);
        tick();
        req_valid = 1'b0;
        chk("held_c12_done", {7'd0, done}, 8'd1);
        chk("held_c12_busy", {7'd0, busy}, 8'd0);
        chk("held_c12_cnt", sw_count, 8'd3);
        tick();
        chk("held_c13_done", {7'd0, done}, 8'd0);

        // reset in the middle of SWITCH
        run_req(1'b0);
        chk("pre_rst_cnt", sw_count, 8'd4);
        req_valid = 1'b1;
        req_mode  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_c2_cmode", {7'd0, cmode}, 8'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_hold", {7'd0, cpu_hold}, 8'd0);
        chk("mid_rst_cmode", {7'd0, cmode}, 8'd0);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_done", {7'd0, done}, 8'd0);
        chk("mid_rst_cnt", sw_count, 8'd0);
        tick();
        chk("mid_rst_err", {7'd0, err_timeout}, 8'd0);
        rst = 1'b0;
        tick();
        chk("mid_post_ready", {7'd0, req_ready}, 8'd1);
        chk("mid_post_done", {7'd0, done}, 8'd0);
        chk("mid_post_err", {7'd0, err_timeout}, 8'd0);

        // 256 switches wrap the counter
        for (int i = 0; i < 255; i++) begin
            run_req((i % 2) == 0);
        end
        chk("wrap_255", sw_count, 8'd255);
        run_req(1'b0);
        chk("wrap_0", sw_count, 8'd0);
        chk("wrap_cmode", {7'd0, cmode}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
